// File: rtl/apb_completer_mem.sv
// APB completer backed by a small register-file memory with programmable wait states,
// misaligned-access error responses and a saturating error counter.
module apb_completer_mem #(
  parameter int unsigned ADDR_W      = 60,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned COMP_ID     = 0
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [7:0]        err_count,
  output logic [3:0]        comp_id_o
);

  localparam int unsigned IdxW     = $clog2(DEPTH);
  localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e              state_q, state_d;
  logic [3:0]          wcnt_q, wcnt_d;
  logic                write_q, write_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                misal_q, misal_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                pready_q, pready_d;
  logic                pslverr_q, pslverr_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;
  logic [7:0]          err_q, err_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];

  logic                err_inc;
  logic                resp_fire;
  logic                resp_write;
  logic [IdxW-1:0]     resp_idx;
  logic                resp_misal;
  logic [IdxW-1:0]     setup_idx;
  logic                setup_misal;

  // Upper address bits are already decoded by the crossbar.
  logic unused_paddr;
  assign unused_paddr = ^paddr[ADDR_W-1:IdxW+2];

  assign setup_idx   = paddr[IdxW+1:2];
  assign setup_misal = |paddr[1:0];

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    write_d    = write_q;
    idx_d      = idx_q;
    misal_d    = misal_q;
    wdata_d    = wdata_q;
    mem_d      = mem_q;
    err_inc    = 1'b0;
    resp_fire  = 1'b0;
    resp_write = write_q;
    resp_idx   = idx_q;
    resp_misal = misal_q;

    unique case (state_q)
      StIdle: begin
        if (psel && !penable) begin
          state_d = StAccess;
          write_d = pwrite;
          idx_d   = setup_idx;
          misal_d = setup_misal;
          wdata_d = pwdata;
          wcnt_d  = WaitInit;
          // Zero-wait: the first access cycle is already the completion cycle.
          if (WaitInit == 4'd0) begin
            resp_fire  = 1'b1;
            resp_write = pwrite;
            resp_idx   = setup_idx;
            resp_misal = setup_misal;
          end
        end else if (psel && penable) begin
          err_inc = 1'b1;
        end
      end
      StAccess: begin
        if (!psel) begin
          state_d = StIdle;
        end else if (wcnt_q != 4'd0) begin
          wcnt_d = wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) begin
            resp_fire = 1'b1;
          end
        end else begin
          state_d = StIdle;
          if (write_q && !misal_q) begin
            mem_d[idx_q] = wdata_q;
          end
          if (misal_q) begin
            err_inc = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Response is registered one edge ahead so the completion cycle has no comb path from psel.
  always_comb begin
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
    if (resp_fire) begin
      pready_d  = 1'b1;
      pslverr_d = resp_misal;
      if (!resp_write && !resp_misal) begin
        prdata_d = mem_q[resp_idx];
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if (err_inc && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q   <= StIdle;
      wcnt_q    <= 4'd0;
      write_q   <= 1'b0;
      idx_q     <= '0;
      misal_q   <= 1'b0;
      wdata_q   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      err_q     <= 8'd0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      write_q   <= write_d;
      idx_q     <= idx_d;
      misal_q   <= misal_d;
      wdata_q   <= wdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      err_q     <= err_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign pready    = pready_q;
  assign pslverr   = pslverr_q;
  assign prdata    = prdata_q;
  assign err_count = err_q;
  assign comp_id_o = 4'(COMP_ID);

endmodule

// File: tb/tb_apb_completer_mem.sv
// Directed bench for apb_completer_mem: one instance with one wait state, one with zero.
module tb_apb_completer_mem;

  logic        pclk = 1'b0;
  logic        preset_n;
  logic        psel_w1, psel_w0, penable, pwrite;
  logic [59:0] paddr;
  logic [31:0] pwdata;

  logic [31:0] prdata_w1, prdata_w0;
  logic        pready_w1, pready_w0, pslverr_w1, pslverr_w0;
  logic [7:0]  err_count_w1, err_count_w0;
  logic [3:0]  comp_id_w1, comp_id_w0;

  bit          use0;
  logic        pready_m, pslverr_m;
  logic [31:0] prdata_m;

  int checks = 0;
  int errors = 0;

  assign pready_m  = use0 ? pready_w0 : pready_w1;
  assign pslverr_m = use0 ? pslverr_w0 : pslverr_w1;
  assign prdata_m  = use0 ? prdata_w0 : prdata_w1;

  always #5 pclk = ~pclk;

  apb_completer_mem #(
    .ADDR_W(60), .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(1), .COMP_ID(2)
  ) u_dut_w1 (
    .pclk(pclk), .preset_n(preset_n), .psel(psel_w1), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_w1), .pready(pready_w1),
    .pslverr(pslverr_w1), .err_count(err_count_w1), .comp_id_o(comp_id_w1)
  );

  apb_completer_mem #(
    .ADDR_W(60), .DATA_W(32), .DEPTH(16), .WAIT_CYCLES(0), .COMP_ID(1)
  ) u_dut_w0 (
    .pclk(pclk), .preset_n(preset_n), .psel(psel_w0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_w0), .pready(pready_w0),
    .pslverr(pslverr_w0), .err_count(err_count_w0), .comp_id_o(comp_id_w0)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    @(posedge pclk);
    #1;
    psel_w1 = 1'b0;
    psel_w0 = 1'b0;
    penable = 1'b0;
  endtask

  // Full transfer; address/data/direction are scrambled during ACCESS to prove they are captured.
  task automatic apb_xfer(input bit dut0, input bit wr, input logic [59:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int cycles);
    bit done;
    use0 = dut0;
    @(posedge pclk);
    #1;
    psel_w0 = dut0;
    psel_w1 = !dut0;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    cycles  = 1;
    rdata   = 32'hx;
    err     = 1'bx;
    done    = 1'b0;
    @(posedge pclk);
    #1;
    penable = 1'b1;
    pwrite  = !wr;
    paddr   = ~addr;
    pwdata  = ~wdata;
    while (!done) begin
      @(negedge pclk);
      cycles++;
      if (pready_m) begin
        rdata = prdata_m;
        err   = pslverr_m;
        done  = 1'b1;
      end else if (cycles > 20) begin
        check_eq("pready_timeout", 64'(cycles), 64'd0);
        done = 1'b1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          cyc;
    bit          seen;

    preset_n = 1'b0;
    psel_w1  = 1'b0;
    psel_w0  = 1'b0;
    penable  = 1'b0;
    pwrite   = 1'b0;
    paddr    = '0;
    pwdata   = '0;
    use0     = 1'b0;

    repeat (3) @(posedge pclk);
    #1;
    check_eq("rst_pready", 64'(pready_w1), 64'd0);
    check_eq("rst_pslverr", 64'(pslverr_w1), 64'd0);
    check_eq("rst_prdata", 64'(prdata_w1), 64'd0);
    check_eq("rst_errcnt", 64'(err_count_w1), 64'd0);
    check_eq("comp_id_w1", 64'(comp_id_w1), 64'd2);
    check_eq("comp_id_w0", 64'(comp_id_w0), 64'd1);
    preset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      apb_xfer(1'b0, 1'b0, 60'(i * 4), 32'h0, rd, er, cyc);
      check_eq($sformatf("rst_rd%0d_data", i), 64'(rd), 64'd0);
      check_eq($sformatf("rst_rd%0d_err", i), 64'(er), 64'd0);
    end
    drive_idle();
    @(negedge pclk);
    check_eq("rst_errcnt_after_reads", 64'(err_count_w1), 64'd0);

    apb_xfer(1'b0, 1'b1, 60'h0_00000008, 32'hDEADBEEF, rd, er, cyc);
    check_eq("w1_wr_cycles", 64'(cyc), 64'd3);
    check_eq("w1_wr_err", 64'(er), 64'd0);
    apb_xfer(1'b0, 1'b0, 60'h0_00000008, 32'h0, rd, er, cyc);
    check_eq("w1_rd_cycles", 64'(cyc), 64'd3);
    check_eq("w1_rd_data", 64'(rd), 64'hDEADBEEF);
    check_eq("w1_rd_err", 64'(er), 64'd0);

    apb_xfer(1'b1, 1'b1, {28'hABCDEF1, 32'h0000003C}, 32'h12345678, rd, er, cyc);
    check_eq("w0_wr_cycles", 64'(cyc), 64'd2);
    apb_xfer(1'b1, 1'b0, {28'h0, 32'h0000003C}, 32'h0, rd, er, cyc);
    check_eq("w0_rd_cycles", 64'(cyc), 64'd2);
    check_eq("w0_rd_alias", 64'(rd), 64'h12345678);

    apb_xfer(1'b0, 1'b1, 60'h2, 32'h55, rd, er, cyc);
    check_eq("mis_wr_err", 64'(er), 64'd1);
    apb_xfer(1'b0, 1'b0, 60'h2, 32'h0, rd, er, cyc);
    check_eq("mis_rd_err", 64'(er), 64'd1);
    check_eq("mis_rd_data", 64'(rd), 64'd0);
    apb_xfer(1'b0, 1'b0, 60'h0, 32'h0, rd, er, cyc);
    check_eq("mis_word0", 64'(rd), 64'd0);
    check_eq("mis_word0_err", 64'(er), 64'd0);
    drive_idle();
    @(negedge pclk);
    check_eq("mis_errcnt", 64'(err_count_w1), 64'd2);

    // Abort: psel dropped in the wait cycle of a write.
    use0 = 1'b0;
    @(posedge pclk);
    #1;
    psel_w1 = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 60'h4;
    pwdata  = 32'hA5A5A5A5;
    @(posedge pclk);
    #1;
    psel_w1 = 1'b0;
    seen    = 1'b0;
    repeat (4) begin
      @(negedge pclk);
      if (pready_w1) seen = 1'b1;
    end
    check_eq("abort_no_pready", 64'(seen), 64'd0);
    apb_xfer(1'b0, 1'b0, 60'h4, 32'h0, rd, er, cyc);
    check_eq("abort_word1", 64'(rd), 64'd0);
    drive_idle();
    @(negedge pclk);
    check_eq("abort_errcnt", 64'(err_count_w1), 64'd2);

    // Access phase with no preceding setup.
    @(posedge pclk);
    #1;
    psel_w1 = 1'b1;
    penable = 1'b1;
    @(negedge pclk);
    check_eq("badseq_pready", 64'(pready_w1), 64'd0);
    @(posedge pclk);
    #1;
    psel_w1 = 1'b0;
    penable = 1'b0;
    @(negedge pclk);
    check_eq("badseq_pready_after", 64'(pready_w1), 64'd0);
    check_eq("badseq_errcnt", 64'(err_count_w1), 64'd3);

    for (int i = 0; i < 300; i++) begin
      apb_xfer(1'b0, 1'b0, 60'h1, 32'h0, rd, er, cyc);
    end
    check_eq("sat_last_err", 64'(er), 64'd1);
    check_eq("sat_last_data", 64'(rd), 64'd0);
    check_eq("sat_last_cycles", 64'(cyc), 64'd3);
    drive_idle();
    @(negedge pclk);
    check_eq("sat_errcnt", 64'(err_count_w1), 64'd255);

    // Reset during the zero-wait completion cycle of a write.
    use0 = 1'b1;
    @(posedge pclk);
    #1;
    psel_w0 = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 60'h0;
    pwdata  = 32'hFFFFFFFF;
    @(posedge pclk);
    #1;
    penable = 1'b1;
    @(negedge pclk);
    check_eq("midrst_pready_before", 64'(pready_w0), 64'd1);
    #1;
    preset_n = 1'b0;
    #1;
    check_eq("midrst_pready", 64'(pready_w0), 64'd0);
    check_eq("midrst_pslverr", 64'(pslverr_w0), 64'd0);
    check_eq("midrst_errcnt_w1", 64'(err_count_w1), 64'd0);
    psel_w0 = 1'b0;
    penable = 1'b0;
    @(posedge pclk);
    #1;
    preset_n = 1'b1;
    apb_xfer(1'b1, 1'b0, 60'h0, 32'h0, rd, er, cyc);
    check_eq("midrst_word0", 64'(rd), 64'd0);
    apb_xfer(1'b1, 1'b0, 60'h3C, 32'h0, rd, er, cyc);
    check_eq("midrst_w0_word15", 64'(rd), 64'd0);
    apb_xfer(1'b0, 1'b0, 60'h8, 32'h0, rd, er, cyc);
    check_eq("midrst_w1_word2", 64'(rd), 64'd0);
    drive_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_completer_mem.md
# apb_completer_mem

APB completer (responder) sitting at one crossbar completer port. It answers the read and write transfers that requesters issue through the crossbar with a small register-file memory. Response latency is programmable through a wait-state count. Misaligned accesses get an error response, and the block keeps a saturating count of errors.

## Interface
- `ADDR_W`, 60: paddr width; crossbar address format is {high 28, low 32}.
- `DATA_W`, 32: pwdata/prdata width.
- `DEPTH`, 16: number of DATA_W-bit words; power of two, 2..256.
- `WAIT_CYCLES`, 1: pready-low cycles inserted in each access phase, 0..15.
- `COMP_ID`, 0: completer index (0..3); only reflected on `comp_id_o`.

Ports:
- `pclk`  in  1  clock; everything is on the rising edge.
- `preset_n`  in  1  reset, asynchronous assert, active-low.
- `psel`  in  1  completer selected.
- `penable`  in  1  access phase.
- `pwrite`  in  1  1 = write, 0 = read.
- `paddr`  in  ADDR_W  byte address.
- `pwdata`  in  DATA_W  write data.
- `prdata`  out  DATA_W  read data; valid only while pready=1 on a read.
- `pready`  out  1  transfer completes this cycle.
- `pslverr`  out  1  error response; valid only while pready=1.
- `err_count`  out  8  saturating count of error responses.
- `comp_id_o`  out  4  constant COMP_ID.

## Operation
- Word index `idx = paddr[log2(DEPTH)+1:2]`.
- paddr bits above the index are ignored; the crossbar has already routed on comp_id.
- Misaligned access (`paddr[1:0] != 0`) gets an error response:
  - write: memory unchanged;
  - read: prdata = 0;
  - pslverr = 1.
- FSM states are IDLE and ACCESS.
- IDLE:
  - `psel=1, penable=0` (setup): capture pwrite, paddr and pwdata; load `wcnt = WAIT_CYCLES`; go to ACCESS.
  - `psel=1, penable=1` with no preceding setup: protocol violation. Ignore it, no response, stay in IDLE, and increment err_count.
- ACCESS:
  - `psel=0`: abort. Return to IDLE; no memory write; err_count unchanged.
  - `wcnt != 0`: pready=0, decrement wcnt.
  - `wcnt == 0`: pready=1. On this edge perform the write (if aligned), increment err_count if the access is misaligned, and go to IDLE.
- Captured values are used for the whole transfer; changes on paddr, pwrite or pwdata during ACCESS are ignored.
- Back-to-back transfers: a setup in the cycle after pready is accepted from IDLE with no bubble.
- err_count saturates at 255 and never wraps.
- Reset:
  - all memory words = 0;
  - state = IDLE, wcnt = 0;
  - pready = 0, pslverr = 0, prdata = 0, err_count = 0;
  - comp_id_o = COMP_ID.
- Reset asserted mid-transfer returns everything to the reset values immediately; the pending write is dropped.

## Timing
- pready, pslverr and prdata are decoded from the registered state and wcnt only, with no combinational path from psel or penable.
- Outside the completion cycle they are all 0.
- Transfer length, counted from setup to the pready cycle inclusive, is `2 + WAIT_CYCLES` cycles:
  - WAIT_CYCLES=0: pready=1 in the first access cycle.
  - WAIT_CYCLES=1: one low cycle, then pready.
- A write is visible to a read whose setup starts in the cycle after the write's pready.
- Sustained throughput is one transfer per `2 + WAIT_CYCLES` cycles.
- err_count updates on the edge that ends the error cycle and is visible in the next cycle.

## Test plan
- **Reset.** Hold preset_n=0 for 3 cycles, release, then read all 16 words.
  - Each read returns 0 with pslverr=0.
  - err_count = 0.
- **Write/read, WAIT_CYCLES=1.** Write 0xDEADBEEF to paddr 0x0_00000008, then read it back.
  - Read returns 0xDEADBEEF.
  - pready is low exactly 1 access cycle per transfer; each transfer is 3 cycles.
- **Upper-bit aliasing, zero-wait.** With WAIT_CYCLES=0, write 0x12345678 to paddr {28'hABCDEF1, 32'h0000003C}, then read {28'h0, 32'h3C}.
  - Read returns 0x12345678.
  - Each transfer is 2 cycles.
- **Misaligned access.** Write 0x55 to paddr 0x2, then read paddr 0x2.
  - Both responses have pslverr=1; the read returns prdata=0.
  - Word 0 is still 0.
  - err_count = 2.
- **Abort and bad sequencing.**
  - Drop psel in the ACCESS wait cycle of a write to 0x4: word 1 is unchanged and no pready is seen.
  - Drive psel=penable=1 from IDLE: err_count increments by 1 and pready stays 0.
- **Back-to-back, saturation, reset mid-transfer.**
  - 300 consecutive misaligned reads: err_count stops at 255.
  - Assert preset_n=0 in the ACCESS cycle of a write of 0xFFFFFFFF to 0x0: outputs clear asynchronously and word 0 reads back as 0.
